// File: rtl/channel_model_pkg.sv
// channel_model_pkg: shared constants and update-FSM encodings for channel_skew_model
package channel_model_pkg;
    localparam logic [65:0] FILL_BLOCK = {2'b10, 8'h1E, 56'h0};
    localparam int MAX_SKEW_DFLT = 16;
    localparam int DEPTH = MAX_SKEW_DFLT + 1;
    localparam int NB_PTR = $clog2(DEPTH);
    typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;
endpackage

// File: rtl/skew_lane_delay.sv
// skew_lane_delay: one lane's circular block buffer with fill gating and registered output
module skew_lane_delay
    import channel_model_pkg::*;
#(
    parameter int MAX_SKEW = DEPTH - 1,
    parameter int PTR_W = NB_PTR,
    parameter int NB_SKEW = PTR_W + 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [PTR_W-1:0]   i_wr_ptr,
    input  logic [NB_SKEW-1:0] i_skew,
    input  logic [65:0]        i_data,
    input  logic               i_tag,
    output logic [65:0]        o_data,
    output logic               o_tag
);
    logic [66:0] mem [MAX_SKEW+1];
    logic [66:0] rd_word;
    logic [NB_SKEW-1:0] fill_cnt, wp;
    logic [PTR_W-1:0] rd_addr;
    assign wp = NB_SKEW'(i_wr_ptr);
    assign rd_addr = PTR_W'((wp >= i_skew) ? wp - i_skew : wp + NB_SKEW'(MAX_SKEW + 1) - i_skew);
    // skew 0 reads the slot being written this beat, so bypass the buffer
    assign rd_word = (i_skew == '0) ? {i_tag, i_data} : mem[rd_addr];
    always_ff @(posedge i_clock)
        if (i_valid)
            mem[i_wr_ptr] <= {i_tag, i_data};
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            fill_cnt <= '0;
            o_data   <= FILL_BLOCK;
            o_tag    <= 1'b0;
        end else if (i_valid) begin
            fill_cnt        <= (fill_cnt == NB_SKEW'(MAX_SKEW)) ? fill_cnt : fill_cnt + 1'b1;
            {o_tag, o_data} <= (i_skew > fill_cnt) ? {1'b0, FILL_BLOCK} : rd_word;
        end
    end
endmodule

// File: rtl/channel_skew_model.sv
// channel_skew_model: run-time programmable per-lane block skew for the PCS loopback bench.
// Lane reordering is built only when CHANNEL_SKEW_LANE_SWAP_EN is defined.
module channel_skew_model
    import channel_model_pkg::*;
#(
    parameter int N_LANES = 20,
    parameter int NB_DATA_CODED = 66,
    parameter int MAX_SKEW = MAX_SKEW_DFLT,
    parameter int NB_SKEW = $clog2(MAX_SKEW + 1) + 1
`ifdef CHANNEL_SKEW_LANE_SWAP_EN
    ,
    parameter int NB_LANE_ID = $clog2(N_LANES)
`endif
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_valid,
    input  logic [N_LANES*NB_DATA_CODED-1:0] i_data,
    input  logic [N_LANES-1:0]               i_tag,
    input  logic [N_LANES*NB_SKEW-1:0]       i_rf_skew_bus,
`ifdef CHANNEL_SKEW_LANE_SWAP_EN
    input  logic [N_LANES*NB_LANE_ID-1:0]    i_rf_lane_map,
`endif
    input  logic                             i_rf_update,
    input  logic                             i_rf_update_mode,
    input  logic                             i_rf_read_clamp,
    output logic [N_LANES*NB_DATA_CODED-1:0] o_data,
    output logic [N_LANES-1:0]               o_tag,
    output logic                             o_valid,
    output logic                             o_rf_busy,
    output logic                             o_rf_skew_clamped
);
    localparam int ptr_w = $clog2(MAX_SKEW + 1);
    state_t state;
    logic mode_q, apply, clamp_hit;
    logic [ptr_w-1:0] wr_ptr;
    logic [0:N_LANES-1][NB_SKEW-1:0] skew_bus, req_skew, shadow_skew, active_skew, eff_skew;
    logic [0:N_LANES-1][NB_DATA_CODED-1:0] data_in, lane_out;
    logic [0:N_LANES-1] tag_in, tag_out;
    assign skew_bus = i_rf_skew_bus;
    assign data_in = i_data;
    assign tag_in = i_tag;
    always_comb begin
        clamp_hit = 1'b0;
        req_skew = skew_bus;
        for (int l = 0; l < N_LANES; l++) begin
            clamp_hit |= skew_bus[l] > NB_SKEW'(MAX_SKEW);
            req_skew[l] = (skew_bus[l] > NB_SKEW'(MAX_SKEW)) ? NB_SKEW'(MAX_SKEW) : skew_bus[l];
        end
    end
    // the applying beat already reads with the shadow skew
    assign apply = (state == ST_PENDING) && i_valid && (!mode_q || tag_in[0]);
    assign eff_skew = apply ? shadow_skew : active_skew;
    assign o_rf_busy = (state == ST_PENDING);
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state             <= ST_IDLE;
            mode_q            <= 1'b0;
            shadow_skew       <= '0;
            active_skew       <= '0;
            wr_ptr            <= '0;
            o_valid           <= 1'b0;
            o_rf_skew_clamped <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid)
                wr_ptr <= (wr_ptr == ptr_w'(MAX_SKEW)) ? '0 : wr_ptr + 1'b1;
            if (apply)
                active_skew <= shadow_skew;
            if (i_rf_update) begin
                shadow_skew <= req_skew;
                mode_q      <= i_rf_update_mode;
            end
            state             <= i_rf_update ? ST_PENDING : apply ? ST_IDLE : state;
            o_rf_skew_clamped <= (i_rf_update && clamp_hit) || (o_rf_skew_clamped && !i_rf_read_clamp);
        end
    end
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        skew_lane_delay #(.MAX_SKEW(MAX_SKEW), .PTR_W(ptr_w), .NB_SKEW(NB_SKEW)) u_lane (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_valid (i_valid),
            .i_wr_ptr(wr_ptr),
            .i_skew  (eff_skew[l]),
            .i_data  (data_in[l]),
            .i_tag   (tag_in[l]),
            .o_data  (lane_out[l]),
            .o_tag   (tag_out[l])
        );
    end
`ifdef CHANNEL_SKEW_LANE_SWAP_EN
    logic [0:N_LANES-1][NB_LANE_ID-1:0] map_bus, map_shadow, map_active;
    logic [0:N_LANES-1][NB_DATA_CODED-1:0] sw_data;
    logic [0:N_LANES-1] sw_tag;
    assign map_bus = i_rf_lane_map;
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int k = 0; k < N_LANES; k++) begin
                map_shadow[k] <= NB_LANE_ID'(k);
                map_active[k] <= NB_LANE_ID'(k);
            end
        end else begin
            if (apply)
                map_active <= map_shadow;
            if (i_rf_update)
                map_shadow <= map_bus;
        end
    end
    always_comb begin
        sw_data = lane_out;
        sw_tag = tag_out;
        for (int k = 0; k < N_LANES; k++) begin
            sw_data[k] = (int'(map_active[k]) < N_LANES) ? lane_out[map_active[k]] : FILL_BLOCK;
            sw_tag[k] = (int'(map_active[k]) < N_LANES) && tag_out[map_active[k]];
        end
    end
    assign o_data = sw_data;
    assign o_tag = sw_tag;
`else
    assign o_data = lane_out;
    assign o_tag = tag_out;
`endif
endmodule

// File: tb/tb_channel_skew_model.sv
// tb_channel_skew_model: directed checks of skew, fill, update FSM, clamp and lane order
module tb_channel_skew_model;
    localparam int N = 20;
    localparam int W = 66;
    localparam int MS = 16;
    localparam int NS = $clog2(MS + 1) + 1;
    localparam int NL = $clog2(N);
    localparam logic [65:0] FILL = {2'b10, 8'h1E, 56'h0};

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    logic i_valid = 1'b0;
    logic [N*W-1:0] i_data = '0;
    logic [N-1:0] i_tag = '0;
    logic [N*NS-1:0] i_rf_skew_bus = '0;
    logic [N*NL-1:0] i_rf_lane_map = '0;
    logic i_rf_update = 1'b0;
    logic i_rf_update_mode = 1'b0;
    logic i_rf_read_clamp = 1'b0;
    logic [N*W-1:0] o_data;
    logic [N-1:0] o_tag;
    logic o_valid, o_rf_busy, o_rf_skew_clamped;
    int checks = 0;
    int failures = 0;
    int n = 0;

    always #5 i_clock = ~i_clock;

    channel_skew_model dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_valid          (i_valid),
        .i_data           (i_data),
        .i_tag            (i_tag),
        .i_rf_skew_bus    (i_rf_skew_bus),
`ifdef CHANNEL_SKEW_LANE_SWAP_EN
        .i_rf_lane_map    (i_rf_lane_map),
`endif
        .i_rf_update      (i_rf_update),
        .i_rf_update_mode (i_rf_update_mode),
        .i_rf_read_clamp  (i_rf_read_clamp),
        .o_data           (o_data),
        .o_tag            (o_tag),
        .o_valid          (o_valid),
        .o_rf_busy        (o_rf_busy),
        .o_rf_skew_clamped(o_rf_skew_clamped)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [65:0] blk(input int l, input int k);
        return {2'b01, 8'(l), 56'(k)};
    endfunction

    function automatic logic [65:0] lane(input int l);
        return o_data[(N-1-l)*W +: W];
    endfunction

    task automatic set_skews(input int s0, input int s1, input int mode);
        i_rf_skew_bus = '0;
        i_rf_skew_bus[(N-1)*NS +: NS] = NS'(s0);
        i_rf_skew_bus[(N-2)*NS +: NS] = NS'(s1);
        i_rf_update_mode = mode[0];
        i_rf_update = 1'b1;
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
        i_valid = 1'b0;
        i_tag = '0;
        i_rf_update = 1'b0;
        i_rf_read_clamp = 1'b0;
    endtask

    task automatic beat(input logic [N-1:0] tag);
        n++;
        for (int l = 0; l < N; l++)
            i_data[(N-1-l)*W +: W] = blk(l, n);
        i_tag = tag;
        i_valid = 1'b1;
        tick();
    endtask

    initial begin
        for (int l = 0; l < N; l++)
            i_rf_lane_map[(N-1-l)*NL +: NL] = NL'(l);
        i_valid = 1'b1;
        i_data = '1;
        repeat (3) @(posedge i_clock);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, {N{FILL}});
        check("rst_tag", o_tag, 0);
        check("rst_busy", o_rf_busy, 0);
        check("rst_clamp", o_rf_skew_clamped, 0);
        i_reset = 1'b1;
        i_valid = 1'b0;

        set_skews(0, 3, 0);
        tick();
        check("upd_busy", o_rf_busy, 1);
        for (int k = 1; k <= 8; k++) begin
            beat('0);
            check("ramp_l0", lane(0), blk(0, n));
            check("ramp_l1", lane(1), (n <= 3) ? FILL : blk(1, n - 3));
            check("ramp_valid", o_valid, 1);
            check("ramp_busy", o_rf_busy, 0);
        end
        tick();
        check("hold_valid", o_valid, 0);
        check("hold_l0", lane(0), blk(0, 8));

        set_skews(5, 3, 1);
        tick();
        for (int k = 1; k <= 45; k++) begin
            beat((k == 40) ? '1 : '0);
            if (k < 40) begin
                check("am_wait_l0", lane(0), blk(0, n));
                check("am_wait_busy", o_rf_busy, 1);
            end else begin
                check("am_l0", lane(0), blk(0, n - 5));
                check("am_busy", o_rf_busy, 0);
            end
            if (k == 45)
                check("am_tag", o_tag, 20'h80000);
        end

        set_skews(25, 3, 0);
        tick();
        check("clamp_set", o_rf_skew_clamped, 1);
        beat('0);
        check("clamp_l0", lane(0), blk(0, n - 16));
        set_skews(25, 3, 0);
        i_rf_read_clamp = 1'b1;
        tick();
        check("clamp_set_wins", o_rf_skew_clamped, 1);
        i_rf_read_clamp = 1'b1;
        tick();
        check("clamp_clear", o_rf_skew_clamped, 0);

        for (int k = 1; k <= 100; k++)
            beat('0);
        check("wrap_l0", lane(0), blk(0, n - 16));
        check("wrap_l1", lane(1), blk(1, n - 3));
        set_skews(2, 3, 0);
        tick();
        beat('0);
        check("dec_l0", lane(0), blk(0, n - 2));
        beat('0);
        check("dec_l0_next", lane(0), blk(0, n - 2));

        set_skews(4, 3, 1);
        tick();
        beat('0);
        check("same_wait_l0", lane(0), blk(0, n - 2));
        set_skews(7, 3, 0);
        beat('1);
        check("same_old_l0", lane(0), blk(0, n - 4));
        check("same_busy", o_rf_busy, 1);
        beat('0);
        check("same_new_l0", lane(0), blk(0, n - 7));
        check("same_idle", o_rf_busy, 0);

        set_skews(0, 0, 0);
        i_rf_lane_map[(N-1)*NL +: NL] = NL'(19);
        i_rf_lane_map[0 +: NL] = NL'(0);
        tick();
        beat('0);
`ifdef CHANNEL_SKEW_LANE_SWAP_EN
        check("swap_l0", lane(0), blk(19, n));
        check("swap_l19", lane(19), blk(0, n));
`else
        check("ident_l0", lane(0), blk(0, n));
        check("ident_l19", lane(19), blk(19, n));
`endif
        check("final_clamp", o_rf_skew_clamped, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
